// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment decode constants, scan state type and nibble decode function
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } scan_state_e;

  // Active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational hex nibble to active-high segment decoder
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg7_decode(nibble_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed hex 7-segment scanner with tear-free value handoff
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000,
  parameter int DEADTIME = 8
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic                  value_valid_i,
  output logic                  value_ready_o,
  input  logic                  blank_lz_i,
  input  logic                  digit_pol_i,
  output logic [6:0]            seg_o,
  output logic [DIGITS-1:0]     dig_en_o,
  output logic [6:0]            seg_oeb_o,
  output logic                  frame_o
);

  localparam int BITS = 4 * DIGITS;
  localparam int CW   = (PRESCALE + DEADTIME > 1) ? $clog2(PRESCALE + DEADTIME) : 1;
  localparam int DW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] SHOW_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((DEADTIME > 0) ? DEADTIME - 1 : 0);
  localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

  scan_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DW-1:0]     dig_q, dig_d, dig_next;
  logic [BITS-1:0]   pend_q, pend_d, disp_q, disp_d;
  logic              pend_full_q, pend_full_d;
  logic [6:0]        seg_q, seg_d, oeb_q;
  logic [DIGITS-1:0] en_q, en_d;
  logic              frame_q, frame_d;
  logic              boundary, accept, zero_run;
  logic [3:0]        nibble;
  logic [6:0]        seg_raw;
  logic [DIGITS-1:0] dig_hot, blank_mask;

  assign value_ready_o = ~pend_full_q;
  assign accept        = value_valid_i & ~pend_full_q;
  assign boundary      = (state_q == SHOW) && (dig_q == '0) && (cnt_q == '0);
  assign dig_next      = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    dig_d   = dig_q;
    case (state_q)
      SHOW: if (cnt_q == SHOW_LAST) begin
        cnt_d = '0;
        if (DEADTIME == 0) begin
          dig_d = dig_next;
        end else begin
          state_d = GAP;
        end
      end
      GAP: if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        state_d = SHOW;
        dig_d   = dig_next;
      end
      default: begin
        state_d = SHOW;
        cnt_d   = '0;
        dig_d   = '0;
      end
    endcase
  end

  // Display only reloads at the frame boundary; a value captured in that same cycle waits a frame.
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    disp_d      = disp_q;
    frame_d     = 1'b0;
    if (boundary && pend_full_q) begin
      disp_d      = pend_q;
      pend_full_d = 1'b0;
      frame_d     = 1'b1;
    end
    if (accept) begin
      pend_d      = value_i;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    nibble     = 4'h0;
    dig_hot    = '0;
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      zero_run = zero_run & (disp_d[4*d +: 4] == 4'h0);
      if (d != 0) blank_mask[d] = blank_lz_i & zero_run;
      if (dig_q == DW'(d)) begin
        nibble     = disp_d[4*d +: 4];
        dig_hot[d] = 1'b1;
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble_i (nibble),
    .seg_o    (seg_raw)
  );

  always_comb begin
    seg_d = {7{~digit_pol_i}};
    en_d  = '0;
    if (state_q == SHOW) begin
      seg_d = seg_raw ^ {7{~digit_pol_i}};
      en_d  = dig_hot & ~blank_mask;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= SHOW;
      cnt_q       <= '0;
      dig_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      disp_q      <= '0;
      seg_q       <= '0;
      en_q        <= '0;
      oeb_q       <= 7'h7F;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      disp_q      <= disp_d;
      seg_q       <= seg_d;
      en_q        <= en_d;
      oeb_q       <= '0;
      frame_q     <= frame_d;
    end
  end

  assign seg_o     = seg_q;
  assign dig_en_o  = en_q;
  assign seg_oeb_o = oeb_q;
  assign frame_o   = frame_q;

endmodule
